// File: rtl/width_conv_pkg.sv
// rtl/width_conv_pkg.sv - shared defaults and ceiling-log2 helper for width converters
package width_conv_pkg;

    localparam int DEF_IN_W  = 8;
    localparam int DEF_RATIO = 2;

    // Ceiling log2, never below 1 so a counter is always at least one bit wide
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >>> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/width_upsizer_if.sv
// rtl/width_upsizer_if.sv - upsizer stream bundle; keep_out present with WIDTH_UPSIZER_KEEP_EN
interface width_upsizer_if
    import width_conv_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int RATIO = DEF_RATIO
) ();

    localparam int OUT_W = IN_W * RATIO;

    logic             valid_in;
    logic             ready_in;
    logic [IN_W-1:0]  data_in;
    logic             last_in;
    logic             valid_out;
    logic             ready_out;
    logic [OUT_W-1:0] data_out;
    logic             last_out;
`ifdef WIDTH_UPSIZER_KEEP_EN
    logic [RATIO-1:0] keep_out;

    modport master (
        output valid_in, data_in, last_in, ready_out,
        input  ready_in, valid_out, data_out, last_out, keep_out
    );

    modport slave (
        input  valid_in, data_in, last_in, ready_out,
        output ready_in, valid_out, data_out, last_out, keep_out
    );
`else
    modport master (
        output valid_in, data_in, last_in, ready_out,
        input  ready_in, valid_out, data_out, last_out
    );

    modport slave (
        input  valid_in, data_in, last_in, ready_out,
        output ready_in, valid_out, data_out, last_out
    );
`endif

endinterface

// File: rtl/width_upsizer.sv
// rtl/width_upsizer.sv - packs RATIO narrow beats MSB-first into one wide word; optional WIDTH_UPSIZER_KEEP_EN
module width_upsizer
    import width_conv_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int RATIO = DEF_RATIO
) (
    input  logic            clk,
    input  logic            rst,
    width_upsizer_if.slave  bus
);

    localparam int OUT_W = IN_W * RATIO;
    localparam int CNT_W = clog2(RATIO);

    logic [CNT_W-1:0] cnt;
    logic [OUT_W-1:0] acc;
    logic [OUT_W-1:0] merged;
    logic [OUT_W-1:0] data_q;
    logic             valid_q;
    logic             last_q;
    logic             ready_int;
    logic             accept;
    logic             closing;

    // The output slot frees up either when empty or when it is being taken this cycle
    assign ready_int = !valid_q || bus.ready_out;
    assign accept    = bus.valid_in && ready_int;
    assign closing   = accept && (bus.last_in || (cnt == CNT_W'(RATIO - 1)));

    assign bus.ready_in  = ready_int;
    assign bus.valid_out = valid_q;
    assign bus.data_out  = data_q;
    assign bus.last_out  = last_q;

    // Accumulator with the incoming beat dropped into its slot; unfilled slots stay zero
    always_comb begin
        merged = acc;
        for (int k = 0; k < RATIO; k++) begin
            if (cnt == CNT_W'(k)) begin
                merged[OUT_W-1-k*IN_W -: IN_W] = bus.data_in;
            end
        end
    end

    // Beat counter and partial-word accumulator; a closing beat empties both
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            if (closing) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= merged;
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Output register: loads on a closing beat (even while the old word leaves), else drains on handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (closing) begin
            data_q  <= merged;
            last_q  <= bus.last_in;
            valid_q <= 1'b1;
        end else if (bus.ready_out) begin
            valid_q <= 1'b0;
        end
    end

`ifdef WIDTH_UPSIZER_KEEP_EN
    logic [RATIO-1:0] keep_acc;
    logic [RATIO-1:0] keep_merged;
    logic [RATIO-1:0] keep_q;

    assign bus.keep_out = keep_q;

    // Slot-fill mask tracks the accumulator; bit RATIO-1 is the first slot
    always_comb begin
        keep_merged = keep_acc;
        for (int k = 0; k < RATIO; k++) begin
            if (cnt == CNT_W'(k)) begin
                keep_merged[RATIO-1-k] = 1'b1;
            end
        end
    end

    // Mask storage follows the same accept/close rules as the data path
    always_ff @(posedge clk) begin
        if (rst) begin
            keep_acc <= '0;
            keep_q   <= '0;
        end else if (accept) begin
            if (closing) begin
                keep_acc <= '0;
                keep_q   <= keep_merged;
            end else begin
                keep_acc <= keep_merged;
            end
        end
    end
`endif

endmodule

// File: tb/tb_width_upsizer.sv
// tb/tb_width_upsizer.sv - randomized and directed bench for width_upsizer (RATIO 2 and 4 instances)
module tb_width_upsizer;

    logic clk;
    logic rst;
    logic v;
    logic l;
    logic [7:0] d;
    logic ro;
    logic sel;

    logic        rdy;
    logic        vo;
    logic        lo;
    logic [31:0] dout;
`ifdef WIDTH_UPSIZER_KEEP_EN
    logic [3:0]  keep;
`endif

    int checks;
    int failures;

    bit [7:0]    beat_d[$];
    bit          beat_l[$];
    logic [31:0] exp_d[$];
    logic        exp_l[$];
    logic [3:0]  exp_k[$];

    width_upsizer_if #(.IN_W(8), .RATIO(2)) ifa ();
    width_upsizer_if #(.IN_W(8), .RATIO(4)) ifb ();

    width_upsizer #(.IN_W(8), .RATIO(2)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
    width_upsizer #(.IN_W(8), .RATIO(4)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

    assign ifa.valid_in  = v && !sel;
    assign ifa.data_in   = d;
    assign ifa.last_in   = l;
    assign ifa.ready_out = ro;
    assign ifb.valid_in  = v && sel;
    assign ifb.data_in   = d;
    assign ifb.last_in   = l;
    assign ifb.ready_out = ro;

    assign rdy  = sel ? ifb.ready_in  : ifa.ready_in;
    assign vo   = sel ? ifb.valid_out : ifa.valid_out;
    assign lo   = sel ? ifb.last_out  : ifa.last_out;
    assign dout = sel ? ifb.data_out  : {16'h0, ifa.data_out};
`ifdef WIDTH_UPSIZER_KEEP_EN
    assign keep = sel ? ifb.keep_out  : {2'b00, ifa.keep_out};
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: group beats into words of up to ratio slots, first beat in the top byte
    task automatic build_expected(input int ratio);
        int n;
        logic [31:0] w;
        n = 0;
        w = '0;
        exp_d.delete();
        exp_l.delete();
        exp_k.delete();
        for (int i = 0; i < beat_d.size(); i++) begin
            w = w | (32'(beat_d[i]) << (8 * (ratio - 1 - n)));
            n = n + 1;
            if (n == ratio || beat_l[i]) begin
                exp_d.push_back(w);
                exp_l.push_back(beat_l[i]);
                exp_k.push_back(4'(((1 << n) - 1) << (ratio - n)));
                w = '0;
                n = 0;
            end
        end
    endtask

    task automatic run_stream(input bit s, input int vprob, input int rprob, output int cycles);
        int idx;
        int filled;
        int ratio;
        bit close_pend;
        bit hold_pend;
        logic [31:0] hold_d;
        logic hold_l;
        idx = 0;
        filled = 0;
        close_pend = 0;
        hold_pend = 0;
        hold_d = '0;
        hold_l = 0;
        ratio = s ? 4 : 2;
        sel = s;
        build_expected(ratio);
        cycles = 0;
        while (exp_d.size() > 0 && cycles < 3000) begin
            @(negedge clk);
            ro = ($urandom_range(99) < rprob);
            if (idx < beat_d.size() && $urandom_range(99) < vprob) begin
                v = 1'b1;
                d = beat_d[idx];
                l = beat_l[idx];
            end else begin
                v = 1'b0;
                d = 8'($urandom);
                l = 1'($urandom);
            end
            #1;
            if (close_pend) begin
                checks++;
                if (vo !== 1'b1) begin
                    failures++;
                    $display("FAIL latency: valid_out=%b required 1 one cycle after closing beat", vo);
                end
            end
            if (hold_pend) begin
                checks++;
                if (vo !== 1'b1 || dout !== hold_d || lo !== hold_l) begin
                    failures++;
                    $display("FAIL hold: valid=%b data=%h last=%b required 1 %h %b", vo, dout, lo, hold_d, hold_l);
                end
            end
            checks++;
            if (rdy !== (!vo || ro)) begin
                failures++;
                $display("FAIL ready_in: got %b required %b", rdy, (!vo || ro));
            end
            close_pend = 0;
            hold_pend = (vo === 1'b1) && !ro;
            hold_d = dout;
            hold_l = lo;
            if (vo === 1'b1 && ro) begin
                checks++;
                if (dout !== exp_d[0] || lo !== exp_l[0]) begin
                    failures++;
                    $display("FAIL word: data=%h last=%b required data=%h last=%b", dout, lo, exp_d[0], exp_l[0]);
                end
`ifdef WIDTH_UPSIZER_KEEP_EN
                checks++;
                if (keep !== exp_k[0]) begin
                    failures++;
                    $display("FAIL keep: got %b required %b", keep, exp_k[0]);
                end
`endif
                void'(exp_d.pop_front());
                void'(exp_l.pop_front());
                void'(exp_k.pop_front());
            end
            if (v && rdy === 1'b1) begin
                filled = filled + 1;
                if (filled == ratio || l) begin
                    close_pend = 1;
                    filled = 0;
                end
                idx = idx + 1;
            end
            cycles = cycles + 1;
        end
        @(negedge clk);
        v = 1'b0;
        ro = 1'b1;
        checks++;
        if (exp_d.size() != 0 || idx != beat_d.size()) begin
            failures++;
            $display("FAIL timeout: %0d words pending, %0d of %0d beats accepted", exp_d.size(), idx, beat_d.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        v = 1'b0;
        l = 1'b0;
        d = 8'h00;
        ro = 1'b0;
        sel = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            checks++;
            if (vo !== 1'b0 || dout !== 32'h0 || lo !== 1'b0) begin
                failures++;
                $display("FAIL reset_state sel=%0d: valid=%b data=%h last=%b required 0 0 0", s, vo, dout, lo);
            end
`ifdef WIDTH_UPSIZER_KEEP_EN
            checks++;
            if (keep !== 4'h0) begin
                failures++;
                $display("FAIL reset_keep sel=%0d: got %b required 0", s, keep);
            end
`endif
        end
        rst = 1'b0;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            checks++;
            if (rdy !== 1'b1) begin
                failures++;
                $display("FAIL reset_ready sel=%0d: got %b required 1", s, rdy);
            end
        end
        sel = 1'b0;
    endtask

    task automatic test_basic();
        int cyc;
        beat_d = '{8'hA1, 8'hB2};
        beat_l = '{1'b0, 1'b0};
        run_stream(1'b0, 100, 100, cyc);
    endtask

    task automatic test_partial_flush();
        int cyc;
        beat_d = '{8'h11, 8'h22, 8'h33};
        beat_l = '{1'b0, 1'b0, 1'b1};
        run_stream(1'b1, 100, 100, cyc);
        beat_d = '{8'h5C};
        beat_l = '{1'b1};
        run_stream(1'b1, 100, 100, cyc);
    endtask

    task automatic test_backpressure();
        sel = 1'b0;
        @(negedge clk);
        ro = 1'b0;
        v = 1'b1;
        d = 8'h01;
        l = 1'b0;
        @(negedge clk);
        d = 8'h02;
        @(negedge clk);
        v = 1'b1;
        d = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (vo !== 1'b1 || dout !== 32'h0102 || rdy !== 1'b0) begin
                failures++;
                $display("FAIL backpressure cycle %0d: valid=%b data=%h ready_in=%b required 1 0102 0", i, vo, dout, rdy);
            end
            @(negedge clk);
        end
        v = 1'b0;
        ro = 1'b1;
        #1;
        checks++;
        if (rdy !== 1'b1) begin
            failures++;
            $display("FAIL bp_release_ready: got %b required 1", rdy);
        end
        @(negedge clk);
        #1;
        checks++;
        if (vo !== 1'b0) begin
            failures++;
            $display("FAIL bp_drain: valid=%b required 0", vo);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        beat_d.delete();
        beat_l.delete();
        for (int i = 1; i <= 8; i++) begin
            beat_d.push_back(8'(i));
            beat_l.push_back(1'b0);
        end
        run_stream(1'b0, 100, 100, cyc);
        checks++;
        if (cyc != 9) begin
            failures++;
            $display("FAIL back_to_back_cycles: got %0d required 9", cyc);
        end
    endtask

    task automatic test_reset_mid_word();
        int cyc;
        sel = 1'b0;
        ro = 1'b1;
        @(negedge clk);
        v = 1'b1;
        d = 8'hAA;
        l = 1'b0;
        @(negedge clk);
        v = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (rdy !== 1'b1 || vo !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_word: ready_in=%b valid=%b required 1 0", rdy, vo);
        end
        beat_d = '{8'h55, 8'h66};
        beat_l = '{1'b0, 1'b0};
        run_stream(1'b0, 100, 100, cyc);
    endtask

    task automatic test_random(input bit s, input int n);
        int cyc;
        beat_d.delete();
        beat_l.delete();
        for (int i = 0; i < n; i++) begin
            beat_d.push_back(8'($urandom));
            beat_l.push_back((i == n - 1) ? 1'b1 : ($urandom_range(99) < 20));
        end
        run_stream(s, 70, 60, cyc);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_partial_flush();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_word();
        test_random(1'b0, 60);
        test_random(1'b1, 60);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/width_upsizer.md
WIDTH_UPSIZER -- requirements
Module: width_upsizer

Interface
REQ-001 SHALL have parameter IN_W, default 8, input beat width in bits (>=1).
REQ-002 SHALL have parameter RATIO, default 2, input beats per output word (2..16).
REQ-003 SHALL derive localparam OUT_W = IN_W*RATIO; not overridable.
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port valid_in  input  1  input beat valid.
REQ-007 SHALL have port ready_in  output  1  block accepts beat when valid_in && ready_in.
REQ-008 SHALL have port data_in  input  IN_W  input beat.
REQ-009 SHALL have port last_in  input  1  beat ends current word early (partial flush).
REQ-010 SHALL have port valid_out  output  1  output word valid.
REQ-011 SHALL have port ready_out  input  1  downstream accepts word when valid_out && ready_out.
REQ-012 SHALL have port data_out  output  OUT_W  assembled word.
REQ-013 SHALL have port last_out  output  1  word was closed by last_in.

Function
REQ-014 SHALL fill slots MSB-first: accepted beat k of a word (k=0..RATIO-1) lands in data_out[OUT_W-1-k*IN_W -: IN_W].
REQ-015 SHALL keep beat counter cnt, width clog2(RATIO), incremented per accepted beat; word closes on beat with cnt==RATIO-1 or last_in=1; cnt then returns to 0.
REQ-016 SHALL present closed word on data_out with valid_out=1 the cycle after the closing beat is accepted (latency 1 from closing beat).
REQ-017 SHALL zero all unfilled slots of a partial word; last_out=1 only when last_in closed the word (last_in on beat RATIO-1 also sets last_out).
REQ-018 SHALL drive ready_in = !valid_out || ready_out, combinational, no dependence on valid_in.
REQ-019 SHALL hold data_out, last_out, (keep_out) stable while valid_out && !ready_out.
REQ-020 SHALL, when an output word is taken and a closing beat is accepted in the same cycle, load the new word with valid_out staying 1 (no bubble); sustained throughput one beat per cycle.
REQ-021 SHALL clear valid_out after handshake when no new word closes that cycle.
REQ-022 SHALL ignore data_in and last_in when valid_in=0; last_in on an empty accumulator with valid_in=1 yields a one-slot word.

Reset
REQ-023 SHALL, while rst=1, force valid_out=0, data_out=0, last_out=0, keep_out=0, cnt=0, accumulator=0.
REQ-024 SHALL discard any partial word and any un-taken output word on reset mid-operation; ready_in=1 the first cycle after rst falls.

Configuration
REQ-025 SHALL, with WIDTH_UPSIZER_KEEP_EN defined, add port keep_out  output  RATIO  per-slot valid mask, bit RATIO-1 = slot 0, 1 for each filled slot.
REQ-026 SHALL, without WIDTH_UPSIZER_KEEP_EN, omit keep_out and its storage; all other behaviour identical.

Structure
REQ-027 SHALL place default IN_W/RATIO constants and the ceiling-log2 function in shared package width_conv_pkg.
REQ-028 SHALL be a single module with no sub-modules; accumulator, counter and output register flat.

Verification
REQ-029 SHALL cover IN_W=8,RATIO=2, ready_out=1: beats 0xA1,0xB2 -> data_out=0xA1B2, last_out=0, keep_out=2'b11, one cycle after 0xB2.
REQ-030 SHALL cover RATIO=4: beats 0x11,0x22,0x33 with last_in on 0x33 -> data_out=0x11223300, last_out=1, keep_out=4'b1110.
REQ-031 SHALL cover backpressure: RATIO=2, ready_out=0 after word 0x0102 -> ready_in=0, data_out holds 0x0102 for 5 cycles, released on ready_out=1.
REQ-032 SHALL cover back-to-back: 8 consecutive beats 0x01..0x08, RATIO=2, ready_out=1 -> words 0x0102,0x0304,0x0506,0x0708 on alternate cycles, no beat dropped.
REQ-033 SHALL cover reset mid-word: beat 0xAA accepted, rst=1 one cycle, then 0x55,0x66 -> single word 0x5566, 0xAA never appears.
